// File: rtl/alu_pkg.sv
// Shared opcodes and FSM encodings for the multi-cycle ALU.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_AND  = 4'd0;
  localparam logic [OP_W-1:0] OP_OR   = 4'd1;
  localparam logic [OP_W-1:0] OP_ADD  = 4'd2;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd3;
  localparam logic [OP_W-1:0] OP_SLTU = 4'd4;
  localparam logic [OP_W-1:0] OP_SBC  = 4'd5;
  localparam logic [OP_W-1:0] OP_ADC  = 4'd6;
  localparam logic [OP_W-1:0] OP_XOR  = 4'd7;
  localparam logic [OP_W-1:0] OP_MULU = 4'd8;
  localparam logic [OP_W-1:0] OP_DIVU = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_addsub.sv
// Width-generic carry-lookahead adder/subtractor: sum = a + (invert_b ? ~b : b) + cin.
module alu_addsub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             invert_b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;

  assign bx = invert_b ? ~b : b;
  assign g  = a & bx;
  assign p  = a ^ bx;

  // Each carry expanded from generate/propagate terms, no ripple through c[].
  always_comb begin
    logic acc;
    logic pp;
    c = '0;
    c[0] = cin;
    for (int i = 0; i < int'(WIDTH); i++) begin
      acc = g[i];
      pp  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      c[i+1] = acc | (pp & cin);
    end
  end

  assign sum  = p ^ c[WIDTH-1:0];
  assign cout = c[WIDTH];

endmodule

// File: rtl/alu_mc.sv
// Registered ALU: single-cycle logic/arith ops, iterative MULU (shift-add) and DIVU (restoring).
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             carry,
  output logic             dz,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               div_q, div_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   result_d, result_hi_d;
  logic               zero_d, carry_d, dz_d, busy_d, done_d;

  logic [WIDTH-1:0]   add_a, add_b, add_sum;
  logic               add_cin, add_inv, add_cout;

  logic               accept;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_hi, mul_lo;
  logic               div_ok;
  logic [WIDTH-1:0]   div_rem, div_quo;
  logic [WIDTH-1:0]   single_res;

  assign accept = start & ~busy;

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a        (add_a),
    .b        (add_b),
    .cin      (add_cin),
    .invert_b (add_inv),
    .sum      (add_sum),
    .cout     (add_cout)
  );

  // Shared adder steering: iteration datapath while in ITER, otherwise the incoming op.
  always_comb begin
    add_a   = data_a;
    add_b   = data_b;
    add_cin = 1'b0;
    add_inv = 1'b0;
    if (state_q == S_ITER) begin
      add_b = b_q;
      if (div_q) begin
        add_a   = shifted[WIDTH-1:0];
        add_cin = 1'b1;
        add_inv = 1'b1;
      end else begin
        add_a = hi_q;
      end
    end else begin
      unique case (op)
        OP_ADC:          add_cin = carry;
        OP_SUB, OP_SLTU: begin add_cin = 1'b1;   add_inv = 1'b1; end
        OP_SBC:          begin add_cin = ~carry; add_inv = 1'b1; end
        default:         add_cin = 1'b0;
      endcase
    end
  end

  // One multiply step: conditionally add multiplicand to the high half, then shift right.
  assign mul_sum = lo_q[0] ? {add_cout, add_sum} : {1'b0, hi_q};
  assign mul_hi  = mul_sum[WIDTH:1];
  assign mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};

  // One restoring-divide step; a set top bit of the shifted remainder guarantees the trial fits.
  assign shifted = {hi_q, lo_q[WIDTH-1]};
  assign div_ok  = shifted[WIDTH] | add_cout;
  assign div_rem = div_ok ? add_sum : shifted[WIDTH-1:0];
  assign div_quo = {lo_q[WIDTH-2:0], div_ok};

  // Single-cycle op results; carry/borrow taken from the shared adder.
  always_comb begin
    single_res = '0;
    unique case (op)
      OP_AND:                  single_res = data_a & data_b;
      OP_OR:                   single_res = data_a | data_b;
      OP_XOR:                  single_res = data_a ^ data_b;
      OP_ADD, OP_ADC,
      OP_SUB, OP_SBC:          single_res = add_sum;
      OP_SLTU:                 single_res = {{(WIDTH-1){1'b0}}, ~add_cout};
      default:                 single_res = '0;
    endcase
  end

  // Next-state and next-register values.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    b_d         = b_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    result_d    = result;
    result_hi_d = result_hi;
    zero_d      = zero;
    carry_d     = carry;
    dz_d        = dz;
    busy_d      = busy;
    done_d      = 1'b0;

    unique case (state_q)
      S_ITER: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (div_q) begin
          hi_d = div_rem;
          lo_d = div_quo;
        end else begin
          hi_d = mul_hi;
          lo_d = mul_lo;
        end
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          result_d    = div_q ? div_quo : mul_lo;
          result_hi_d = div_q ? div_rem : mul_hi;
          zero_d      = div_q ? (div_quo == '0) : (mul_lo == '0);
          dz_d        = div_q & (b_q == '0);
          busy_d      = 1'b0;
          done_d      = 1'b1;
          state_d     = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        if (accept) begin
          if (op == OP_MULU || op == OP_DIVU) begin
            div_d   = (op == OP_DIVU);
            b_d     = data_b;
            hi_d    = '0;
            lo_d    = data_a;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = S_ITER;
          end else begin
            result_d    = single_res;
            result_hi_d = '0;
            zero_d      = (single_res == '0);
            dz_d        = 1'b0;
            done_d      = 1'b1;
            state_d     = S_DONE;
            unique case (op)
              OP_ADD, OP_ADC: carry_d = add_cout;
              OP_SUB, OP_SBC: carry_d = ~add_cout;
              default:        carry_d = carry;
            endcase
          end
        end
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      div_q     <= 1'b0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      result    <= '0;
      result_hi <= '0;
      zero      <= 1'b1;
      carry     <= 1'b0;
      dz        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      b_q       <= b_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      result    <= result_d;
      result_hi <= result_hi_d;
      zero      <= zero_d;
      carry     <= carry_d;
      dz        <= dz_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule
